// File: rtl/fast_domain_fifo.sv
// Single-clock first-word-fall-through buffer for the 250 MHz domain.
// The writer cannot be stalled, so writes that arrive while full are dropped and latched in a sticky overflow flag.
module fast_domain_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                         clkIn,
    input  logic                         rstNIn,
    input  logic                         flushIn,
    input  logic                         wrEnIn,
    input  logic [DATA_WIDTH-1:0]        wrDataIn,
    input  logic                         rdReadyIn,
    output logic [DATA_WIDTH-1:0]        rdDataOut,
    output logic                         rdValidOut,
    output logic [$clog2(DEPTH+1)-1:0]   countOut,
    output logic                         fullOut,
    output logic                         almostFullOut,
    output logic                         overflowOut
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  ovf_q, ovf_d;
    logic                  pop, push, drop;

    always_comb begin
        pop  = rd_valid_q & rdReadyIn;
        push = wrEnIn & (~full_q | pop);
        drop = wrEnIn & full_q & ~pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        ovf_d      = ovf_q;

        if (flushIn) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            ovf_d      = ovf_q | drop;
            rd_valid_d = (count_d != '0);
            // The new head may be the word being written this cycle (empty, or a single word being popped).
            if (count_d != '0) begin
                if (push && (wr_ptr_q == rd_ptr_d)) rd_data_d = wrDataIn;
                else                                rd_data_d = mem_q[rd_ptr_d];
            end
        end

        full_d  = (count_d == DEPTH_C);
        afull_d = (count_d >= AFULL_C);
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clkIn) begin
        if (push && !flushIn) mem_q[wr_ptr_q] <= wrDataIn;
    end

    assign rdDataOut     = rd_data_q;
    assign rdValidOut    = rd_valid_q;
    assign countOut      = count_q;
    assign fullOut       = full_q;
    assign almostFullOut = afull_q;
    assign overflowOut   = ovf_q;

endmodule

// File: tb/tb_fast_domain_fifo.sv
// Directed bench for fast_domain_fifo: stimulus queues expected words, a monitor pops and compares on every handshake.
module tb_fast_domain_fifo;

    logic       clkIn = 1'b0;
    logic       rstNIn;
    logic       flushIn;
    logic       wrEnIn;
    logic [7:0] wrDataIn;
    logic       rdReadyIn;
    logic [7:0] rdDataOut;
    logic       rdValidOut;
    logic [4:0] countOut;
    logic       fullOut;
    logic       almostFullOut;
    logic       overflowOut;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    fast_domain_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(12)) dut (
        .clkIn(clkIn), .rstNIn(rstNIn), .flushIn(flushIn), .wrEnIn(wrEnIn),
        .wrDataIn(wrDataIn), .rdReadyIn(rdReadyIn), .rdDataOut(rdDataOut),
        .rdValidOut(rdValidOut), .countOut(countOut), .fullOut(fullOut),
        .almostFullOut(almostFullOut), .overflowOut(overflowOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic accepted);
        wrEnIn   = 1'b1;
        wrDataIn = d;
        if (accepted) exp_q.push_back(d);
    endtask

    // Monitor: a handshake is seen at the falling edge ahead of the edge that performs the pop.
    initial begin
        forever begin
            @(negedge clkIn);
            if (rstNIn && !flushIn && rdValidOut && rdReadyIn) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected actual=%0h required=none", rdDataOut);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rdDataOut !== e) begin
                        bad++;
                        $display("FAIL pop_data actual=%0h required=%0h at %0t", rdDataOut, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstNIn = 1'b0; flushIn = 1'b0; wrEnIn = 1'b0; wrDataIn = 8'h00; rdReadyIn = 1'b0;
        #2;
        chk("rst_valid", rdValidOut, 0);
        chk("rst_count", countOut, 0);
        chk("rst_data", rdDataOut, 0);
        chk("rst_full", fullOut, 0);
        chk("rst_afull", almostFullOut, 0);
        chk("rst_ovf", overflowOut, 0);
        #6 rstNIn = 1'b1;
        repeat (9) tick();

        // Basic latency with reader stalled
        wr(8'hA5, 1'b1);
        tick();
        wrEnIn = 1'b0;
        chk("lat_valid", rdValidOut, 1);
        chk("lat_data", rdDataOut, 8'hA5);
        chk("lat_count", countOut, 1);
        repeat (3) tick();
        chk("lat_hold_data", rdDataOut, 8'hA5);
        chk("lat_hold_count", countOut, 1);
        rdReadyIn = 1'b1;
        tick();
        rdReadyIn = 1'b0;
        chk("lat_drain_count", countOut, 0);
        chk("lat_drain_valid", rdValidOut, 0);

        // Fill past full: 17 writes, the last is dropped
        for (int k = 1; k <= 17; k++) begin
            int c;
            wr(8'(k - 1), k <= 16);
            tick();
            c = (k > 16) ? 16 : k;
            chk("fill_count", countOut, c);
            chk("fill_afull", almostFullOut, c >= 12);
            chk("fill_full", fullOut, c == 16);
            chk("fill_ovf", overflowOut, k >= 17);
        end
        wrEnIn = 1'b0;
        tick();
        chk("fill_hold_count", countOut, 16);
        chk("fill_hold_ovf", overflowOut, 1);
        rdReadyIn = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            chk("drain_count", countOut, 16 - j);
        end
        rdReadyIn = 1'b0;
        chk("drain_valid", rdValidOut, 0);
        chk("drain_ovf_sticky", overflowOut, 1);
        flushIn = 1'b1;
        tick();
        flushIn = 1'b0;
        chk("flush_clr_ovf", overflowOut, 0);

        // Full with simultaneous push and pop
        for (int k = 0; k < 16; k++) begin
            wr(8'h20 + 8'(k), 1'b1);
            tick();
        end
        chk("pp_pre_full", fullOut, 1);
        wr(8'h55, 1'b1);
        rdReadyIn = 1'b1;
        tick();
        wrEnIn = 1'b0;
        chk("pp_count", countOut, 16);
        chk("pp_full", fullOut, 1);
        chk("pp_ovf", overflowOut, 0);
        chk("pp_head", rdDataOut, 8'h21);
        repeat (16) tick();
        rdReadyIn = 1'b0;
        chk("pp_drained", countOut, 0);
        chk("pp_queue_empty", exp_q.size(), 0);

        // Streaming through the pointer wrap
        rdReadyIn = 1'b1;
        for (int k = 0; k < 100; k++) begin
            wr(8'(k), 1'b1);
            tick();
            chk("stream_valid", rdValidOut, 1);
            chk("stream_count_le1", countOut <= 5'd1, 1);
        end
        wrEnIn = 1'b0;
        tick();
        rdReadyIn = 1'b0;
        chk("stream_end_count", countOut, 0);

        // Flush at count 7 with overflow set, with a concurrent write
        for (int k = 0; k < 17; k++) begin
            wr(8'h40 + 8'(k), k < 16);
            tick();
        end
        wrEnIn = 1'b0;
        rdReadyIn = 1'b1;
        repeat (9) tick();
        rdReadyIn = 1'b0;
        chk("fl_pre_count", countOut, 7);
        chk("fl_pre_ovf", overflowOut, 1);
        chk("fl_pre_head", rdDataOut, 8'h49);
        flushIn = 1'b1;
        wrEnIn = 1'b1;
        wrDataIn = 8'hEE;
        exp_q.delete();
        tick();
        flushIn = 1'b0;
        wrEnIn = 1'b0;
        chk("fl_count", countOut, 0);
        chk("fl_valid", rdValidOut, 0);
        chk("fl_ovf", overflowOut, 0);
        chk("fl_afull", almostFullOut, 0);
        chk("fl_data_hold", rdDataOut, 8'h49);
        tick();
        chk("fl_write_ignored", countOut, 0);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 5; k++) begin
            wr(8'h60 + 8'(k), 1'b1);
            tick();
        end
        wrEnIn = 1'b0;
        chk("ar_pre_count", countOut, 5);
        #2 rstNIn = 1'b0;
        #1;
        exp_q.delete();
        chk("ar_count", countOut, 0);
        chk("ar_valid", rdValidOut, 0);
        chk("ar_data", rdDataOut, 0);
        chk("ar_full", fullOut, 0);
        chk("ar_afull", almostFullOut, 0);
        chk("ar_ovf", overflowOut, 0);
        #4 rstNIn = 1'b1;
        tick();
        wr(8'h77, 1'b1);
        tick();
        wrEnIn = 1'b0;
        chk("ar_post_count", countOut, 1);
        chk("ar_post_data", rdDataOut, 8'h77);
        chk("ar_post_valid", rdValidOut, 1);
        rdReadyIn = 1'b1;
        tick();
        rdReadyIn = 1'b0;
        chk("ar_post_drain", countOut, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
